vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_pkg.sv | 18 +
 rtl/vram_arbiter_sat_cnt.sv | 36 +++
 rtl/vram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared types and defaults for the VRAM arbiter: port owner, CPU handshake state, pre-emption limit.
package vram_arbiter_pkg;

  localparam int MAX_WAIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_CPU
  } owner_e;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_ACK
  } cpu_state_e;

endpackage

// File: rtl/vram_arbiter_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment, holds at MAX.
module vram_arbiter_sat_cnt #(
  parameter int          W   = 8,
  parameter int unsigned MAX = 2**W - 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM shared by video (priority, denied reads are dropped) and CPU (req/ack, pre-empts after MAX_WAIT denials).
// Read data arrives 1 cycle after grant; stat counters exist only with VRAM_ARBITER_STATS_EN defined.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [11:0] vid_addr,
  output logic [7:0]  vid_dout,
  output logic        vid_valid,
  output logic        vid_drop,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [15:0] stat_conflicts,
  output logic [7:0]  stat_drops
);

  localparam logic [2:0] WAIT_MAX = 3'(MAX_WAIT);

  cpu_state_e  state_q;
  owner_e      own;
  logic        lock_q;
  logic        cpu_ack_q, we_q;
  logic        vid_valid_q, vid_drop_q;
  logic [7:0]  cpu_dout_q, vid_dout_q;
  logic [11:0] addr_q;
  logic [2:0]  wait_cnt;
  logic        cpu_pend, cpu_force;

  // A served request stays locked out until cpu_req is seen low, so holding
  // the line past the ack never turns into a second access.
  assign cpu_pend  = cpu_req && !lock_q && !reset;
  assign cpu_force = cpu_pend && (wait_cnt == WAIT_MAX);

  always_comb begin
    own = OWN_NONE;
    if (!reset) begin
      if (vid_req && !cpu_force) begin
        own = OWN_VID;
      end else if (cpu_pend) begin
        own = OWN_CPU;
      end
    end
  end

  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    case (own)
      OWN_VID: ram_addr = vid_addr;
      OWN_CPU: begin
        ram_addr  = cpu_addr;
        ram_we    = cpu_we;
        ram_wdata = cpu_din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= 12'h000;
      vid_valid_q <= 1'b0;
      vid_drop_q  <= 1'b0;
      vid_dout_q  <= 8'h00;
    end else begin
      if (own != OWN_NONE) addr_q <= ram_addr;
      vid_valid_q <= (own == OWN_VID);
      vid_drop_q  <= vid_req && (own != OWN_VID);
      if (vid_valid_q) vid_dout_q <= ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= C_IDLE;
      cpu_ack_q  <= 1'b0;
      lock_q     <= 1'b0;
      we_q       <= 1'b0;
      cpu_dout_q <= 8'h00;
    end else begin
      cpu_ack_q <= 1'b0;
      if (own == OWN_CPU) begin
        lock_q <= 1'b1;
      end else if (!cpu_req) begin
        lock_q <= 1'b0;
      end
      case (state_q)
        C_IDLE: begin
          if (own == OWN_CPU) begin
            state_q   <= C_ACK;
            cpu_ack_q <= 1'b1;
            we_q      <= cpu_we;
          end else if (cpu_pend) begin
            state_q <= C_WAIT;
          end
        end
        C_WAIT: begin
          if (own == OWN_CPU) begin
            state_q   <= C_ACK;
            cpu_ack_q <= 1'b1;
            we_q      <= cpu_we;
          end else if (!cpu_req) begin
            state_q <= C_IDLE;
          end
        end
        C_ACK: begin
          state_q <= C_IDLE;
          if (!we_q) cpu_dout_q <= ram_rdata;
        end
        default: state_q <= C_IDLE;
      endcase
    end
  end

  // Reset masks pulses already registered from the cycle before it.
  assign cpu_ack   = cpu_ack_q && !reset;
  assign vid_valid = vid_valid_q && !reset;
  assign vid_drop  = vid_drop_q && !reset;
  assign cpu_dout  = (cpu_ack && !we_q) ? ram_rdata : cpu_dout_q;
  assign vid_dout  = vid_valid ? ram_rdata : vid_dout_q;

  vram_arbiter_sat_cnt #(.W(3), .MAX(MAX_WAIT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i ((own == OWN_CPU) || !cpu_pend),
    .inc_i (cpu_pend && (own != OWN_CPU)),
    .cnt_o (wait_cnt)
  );

`ifdef VRAM_ARBITER_STATS_EN
  vram_arbiter_sat_cnt #(.W(16)) u_conflicts (
    .clk   (clk),
    .reset (reset),
    .clr_i (1'b0),
    .inc_i (vid_req && cpu_req),
    .cnt_o (stat_conflicts)
  );

  vram_arbiter_sat_cnt #(.W(8)) u_drops (
    .clk   (clk),
    .reset (reset),
    .clr_i (1'b0),
    .inc_i (vid_req && (own != OWN_VID)),
    .cnt_o (stat_drops)
  );
`else
  assign stat_conflicts = 16'h0000;
  assign stat_drops     = 8'h00;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus random traffic against a cycle-level transaction model.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam int MAX_WAIT = MAX_WAIT_DEFAULT;
`ifdef VRAM_ARBITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, vid_req = 1'b0;
  logic [11:0] cpu_addr = 12'h000, vid_addr = 12'h000;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout, vid_dout, ram_wdata, ram_rdata;
  logic [11:0] ram_addr;
  logic        cpu_ack, vid_valid, vid_drop, ram_we;
  logic [15:0] stat_conflicts;
  logic [7:0]  stat_drops;

  int tests = 0, fails = 0, wr_count = 0;

  logic [7:0] mem [4096];
  bit         wr_flag [4096];
  logic [7:0] mm [4096];

  bit          exp_ack, exp_vvalid, exp_vdrop, locked;
  logic [7:0]  exp_cdout, exp_vdout;
  logic [11:0] last_addr;
  int          waited, exp_conf, exp_drops;
  bit          active;
  int          hold_left, w0;

  always #5 clk = ~clk;

  vram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout),
    .vid_valid(vid_valid), .vid_drop(vid_drop),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stat_conflicts(stat_conflicts), .stat_drops(stat_drops)
  );

  function automatic logic [7:0] init_val(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5C;
  endfunction

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      wr_flag[ram_addr] <= 1'b1;
      wr_count          <= wr_count + 1;
    end
    ram_rdata <= wr_flag[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already applied; predict ownership, check RAM port mid-cycle,
  // then check the registered results just after the edge.
  task automatic tick();
    bit pend, force_c, vg, cg;
    pend    = cpu_req && !locked && !reset;
    force_c = pend && (waited >= MAX_WAIT);
    vg      = vid_req && !reset && !force_c;
    cg      = pend && !vg;
    #3;
    if (!reset) begin
      chk("ram_we", 32'(ram_we), 32'(cg && cpu_we));
      if (vg)      chk("ram_addr_vid", 32'(ram_addr), 32'(vid_addr));
      else if (cg) chk("ram_addr_cpu", 32'(ram_addr), 32'(cpu_addr));
      else         chk("ram_addr_hold", 32'(ram_addr), 32'(last_addr));
      if (cg && cpu_we) chk("ram_wdata", 32'(ram_wdata), 32'(cpu_din));
    end
    if (reset) begin
      exp_ack = 0; exp_vvalid = 0; exp_vdrop = 0; locked = 0; waited = 0;
      exp_cdout = 8'h00; exp_vdout = 8'h00; last_addr = 12'h000;
      exp_conf = 0; exp_drops = 0;
    end else begin
      if (vid_req && cpu_req && exp_conf < 65535) exp_conf++;
      if (vid_req && !vg && exp_drops < 255) exp_drops++;
      exp_vdrop  = vid_req && !vg;
      exp_vvalid = vg;
      exp_ack    = cg;
      if (vg) begin
        exp_vdout = mm[vid_addr];
        last_addr = vid_addr;
      end
      if (cg) begin
        last_addr = cpu_addr;
        if (cpu_we) mm[cpu_addr] = cpu_din;
        else        exp_cdout = mm[cpu_addr];
        locked = 1;
      end else if (!cpu_req) begin
        locked = 0;
      end
      waited = (pend && !cg) ? ((waited < MAX_WAIT) ? waited + 1 : MAX_WAIT) : 0;
    end
    @(posedge clk);
    #1;
    chk("cpu_ack", 32'(cpu_ack), 32'(exp_ack));
    chk("vid_valid", 32'(vid_valid), 32'(exp_vvalid));
    chk("vid_drop", 32'(vid_drop), 32'(exp_vdrop));
    chk("cpu_dout", 32'(cpu_dout), 32'(exp_cdout));
    chk("vid_dout", 32'(vid_dout), 32'(exp_vdout));
    chk("stat_conflicts", 32'(stat_conflicts), STATS ? 32'(exp_conf) : 32'd0);
    chk("stat_drops", 32'(stat_drops), STATS ? 32'(exp_drops) : 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mm[i] = init_val(12'(i));

    // Reset state
    reset = 1; tick(); tick(); reset = 0;
    chk("rst_ram_addr", 32'(ram_addr), 32'h000);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_cpu_dout", 32'(cpu_dout), 32'h00);

    // Uncontended CPU read of 0x3A5
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h3A5; tick();
    chk("d034_ack", 32'(cpu_ack), 32'd1);
    chk("d034_dout", 32'(cpu_dout), 32'(init_val(12'h3A5)));
    cpu_req = 0; tick();

    // Video and CPU write collide: video first, CPU next cycle
    vid_req = 1; vid_addr = 12'h0F0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h123; cpu_din = 8'h55; tick();
    vid_req = 0;
    chk("d035_valid", 32'(vid_valid), 32'd1);
    chk("d035_vdout", 32'(vid_dout), 32'(init_val(12'h0F0)));
    chk("d035_noack", 32'(cpu_ack), 32'd0);
    tick();
    chk("d035_ack", 32'(cpu_ack), 32'd1);
    chk("d035_mem", 32'(mem[12'h123]), 32'h55);
    cpu_req = 0; tick();

    // Continuous video: CPU pre-empts on its fifth cycle
    reset = 1; tick(); reset = 0;
    vid_req = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 12'h0AA; cpu_din = 8'h5A;
    for (int i = 1; i <= 5; i++) begin
      vid_addr = 12'($urandom);
      tick();
      chk("d036_ack", 32'(cpu_ack), 32'(i == 5));
      chk("d036_drop", 32'(vid_drop), 32'(i == 5));
    end
    chk("d036_stat_drops", 32'(stat_drops), STATS ? 32'd1 : 32'd0);
    tick();
    cpu_req = 0; vid_req = 0; tick();

    // cpu_req held well past ack: one write only
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h321; cpu_din = 8'hC3;
    w0 = wr_count;
    for (int i = 0; i < 5; i++) tick();
    cpu_req = 0; tick();
    chk("d037_writes", 32'(wr_count - w0), 32'd1);

    // Request abandoned before grant
    vid_req = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 12'h777; tick();
    cpu_req = 0; tick();
    vid_req = 0; tick();
    chk("d027_noack", 32'(cpu_ack), 32'd0);

    // Reset while CPU waits
    vid_req = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h456; tick(); tick();
    reset = 1; cpu_req = 0; vid_req = 0; tick(); reset = 0;
    chk("d038_ack", 32'(cpu_ack), 32'd0);
    chk("d038_valid", 32'(vid_valid), 32'd0);
    chk("d038_vdout", 32'(vid_dout), 32'h00);
    chk("d038_ram_addr", 32'(ram_addr), 32'h000);
    chk("d038_ram_we", 32'(ram_we), 32'd0);
    cpu_req = 1; cpu_addr = 12'h3A5; tick();
    chk("d038_idle_grant", 32'(cpu_ack), 32'd1);
    cpu_req = 0; tick();

    // Random traffic, including address changes while waiting and late releases
    active = 0; hold_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (exp_ack) begin
        active = 0;
        hold_left = $urandom_range(0, 3);
      end else if (!active) begin
        if (hold_left > 0) hold_left--;
        else if (cpu_req) cpu_req = 0;
        else if ($urandom_range(0, 2) == 0) begin
          cpu_req = 1; active = 1; cpu_we = 1'($urandom);
          cpu_addr = 12'($urandom); cpu_din = 8'($urandom);
        end
      end else if ($urandom_range(0, 31) == 0) begin
        cpu_req = 0; active = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        cpu_addr = 12'($urandom); cpu_din = 8'($urandom);
      end
      vid_req  = 1'($urandom);
      vid_addr = 12'($urandom);
      tick();
    end

    // Sustained contention for the conflict counter
    cpu_req = 1; cpu_we = 0; vid_req = 1;
    for (int n = 0; n < (STATS ? 70000 : 300); n++) begin
      vid_addr = 12'($urandom);
      tick();
    end
    chk("d039_conflicts", 32'(stat_conflicts), STATS ? 32'hFFFF : 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
